// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a one-clk pulse on its synced rising edge.
module uart_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], d};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~prev_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive sampler: oversampled start/data/stop sampling into a valid/ready holding register.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 EN,
  input  logic                 BCLK,
  input  logic                 RxD,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 rx_parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_ONE     = BW'(1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic tick, bclk_level_unused;
  logic rxd_s, rxd_rise_unused;

  uart_sync_edge #(.RESET_VAL(1'b0)) u_bclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (BCLK),
    .level(bclk_level_unused),
    .rise (tick)
  );

  uart_sync_edge #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (RxD),
    .level(rxd_s),
    .rise (rxd_rise_unused)
  );

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 commit, load;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    armed_d    = armed_q;
    commit     = 1'b0;

    if (!EN) begin
      state_d    = IDLE;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      armed_d    = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        // A start edge only counts once the line has been seen high (break lockout).
        IDLE: begin
          if (rxd_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = START;
            tick_cnt_d = T_ONE;
            armed_d    = 1'b0;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_M1) begin
            if (rxd_s) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              ferr_d     = 1'b0;
              perr_d     = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + T_ONE;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = PARITY;
`else
              state_d   = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + B_ONE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + T_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            perr_d     = (^shift_q) ^ rxd_s ^ parity_odd;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + T_ONE;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            ferr_d     = ferr_q | ~rxd_s;
            if (bit_cnt_q == STOP_LAST) begin
              commit    = 1'b1;
              state_d   = IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + B_ONE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + T_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A commit is accepted when the holder is empty or being drained this same cycle.
  always_comb begin
    load         = commit && (!valid_q || rx_ready);
    data_d       = load ? shift_q : data_q;
    frame_err_d  = load ? ferr_d : frame_err_q;
    parity_err_d = load ? perr_d : parity_err_q;
    valid_d      = load ? 1'b1 : (valid_q && !rx_ready);
    overrun_d    = commit && valid_q && !rx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      armed_q      <= 1'b0;
      data_q       <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      armed_q      <= armed_d;
      data_q       <= data_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_frame_err = frame_err_q;
  assign rx_valid     = valid_q;
  assign overrun_err  = overrun_q;
  assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = parity_err_q;
`else
  logic parity_err_unused;
  assign parity_err_unused = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler (default parameters); parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_sampler;

  localparam int unsigned BIT_CLKS = 64;  // 16 ticks per bit, one tick per 4 clks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       EN = 1'b1;
  logic       BCLK = 1'b0;
  logic       RxD = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_frame_err, rx_valid, overrun_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
  logic       rx_parity_err;
`endif

  uart_rx_sampler #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .EN           (EN),
    .BCLK         (BCLK),
    .RxD          (RxD),
`ifdef UART_RX_PARITY_EN
    .parity_odd   (parity_odd),
    .rx_parity_err(rx_parity_err),
`endif
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .overrun_err  (overrun_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (2) @(posedge clk);
      BCLK = ~BCLK;
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   ovr_cnt = 0;
  bit   hs_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b, input bit expect_out);
    exp_t e;
    e.d  = d;
    e.fe = ~stop_b;
`ifdef UART_RX_PARITY_EN
    e.pe = (^d) ^ par_b ^ parity_odd;
`else
    e.pe = 1'b0;
`endif
    if (expect_out) exp_q.push_back(e);
    RxD = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    RxD = par_b;
    wait_clks(BIT_CLKS);
`endif
    RxD = stop_b;
    wait_clks(BIT_CLKS);
    RxD = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_prev) begin
        chk("valid_drop", {31'b0, rx_valid}, 32'd0);
        hs_prev = 1'b0;
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {31'b0, rx_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rx_data", {24'b0, rx_data}, {24'b0, e.d});
          chk("rx_frame_err", {31'b0, rx_frame_err}, {31'b0, e.fe});
`ifdef UART_RX_PARITY_EN
          chk("rx_parity_err", {31'b0, rx_parity_err}, {31'b0, e.pe});
`endif
        end
        hs_prev = 1'b1;
      end
      if (overrun_err) ovr_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clks(5);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_data", {24'b0, rx_data}, 32'd0);
    chk("rst_ferr", {31'b0, rx_frame_err}, 32'd0);
    chk("rst_ovr", {31'b0, overrun_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    wait_clks(BIT_CLKS);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);

    // Short low pulse: rejected at the mid-start sample.
    RxD = 1'b0;
    wait_clks(12);
    @(negedge clk);
    chk("glitch_busy_hi", {31'b0, busy}, 32'd1);
    wait_clks(4);
    RxD = 1'b1;
    wait_clks(200);
    @(negedge clk);
    chk("glitch_busy_lo", {31'b0, busy}, 32'd0);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_clks(BIT_CLKS);

    // Overrun: second frame dropped while the first is still held.
    rx_ready = 1'b0;
    ovr_cnt  = 0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_valid_held", {31'b0, rx_valid}, 32'd1);
    chk("ovr_data_kept", {24'b0, rx_data}, 32'h11);
    chk("ovr_pulses", ovr_cnt, 32'd1);
    wait_clks(1);
    rx_ready = 1'b1;
    wait_clks(BIT_CLKS);

    // EN dropped mid bit 3 of 0xFF: partial frame discarded.
    RxD = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      RxD = 1'b1;
      wait_clks(BIT_CLKS);
    end
    wait_clks(BIT_CLKS / 2);
    EN = 1'b0;
    wait_clks(2);
    @(negedge clk);
    chk("en_busy_lo", {31'b0, busy}, 32'd0);
    wait_clks(8);
    EN = 1'b1;
    wait_clks(BIT_CLKS * 7);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);

    // Break: one frame of zeros with framing error, then no re-arm while low.
`ifdef UART_RX_PARITY_EN
    exp_q.push_back('{d: 8'h00, fe: 1'b1, pe: parity_odd});
`else
    exp_q.push_back('{d: 8'h00, fe: 1'b1, pe: 1'b0});
`endif
    RxD = 1'b0;
    wait_clks(BIT_CLKS * 30);
    @(negedge clk);
    chk("break_busy_lo", {31'b0, busy}, 32'd0);
    RxD = 1'b1;
    wait_clks(BIT_CLKS * 2);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    wait_clks(4);
    chk("drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- UART receive stage directly downstream of the baud-rate generator; consumes its BCLK (one rising edge = one oversample tick) in the system clk domain.
- Synchronises the serial line, detects and validates the start bit, samples data/stop bits at mid-bit, and presents each frame on a valid/ready holding register with framing and overrun status.
- Feeds the host-side RX FIFO / register interface.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLE, 16, BCLK ticks per bit (even, >=4); matches the generator's oversampling rate.
- STOP_BITS, 1, stop bits checked (1 or 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- EN  input  1  receiver enable; 0 forces FSM to IDLE (synchronous), holding register untouched.
- BCLK  input  1  baud/oversample clock level from generator; rising edge detected in clk domain.
- RxD  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  received frame, valid while rx_valid=1.
- rx_frame_err  output  1  stop bit sampled 0 for this frame, qualified by rx_valid.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts; transfer on rx_valid&&rx_ready at clk edge.
- overrun_err  output  1  one-clk pulse: completed frame dropped because holding register full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM IDLE; synchronisers preset to 1 (RxD) and 0 (BCLK).
- 2-flop synchroniser on RxD and on BCLK; tick = synced BCLK rising edge (1-clk pulse). All bit timing advances only on tick.
- tick_cnt width clog2(OVERSAMPLE); bit_cnt width clog2(DATA_BITS+1).
- IDLE: on tick with synced RxD=0 -> START, tick_cnt=1.
- START: count ticks; at tick_cnt==OVERSAMPLE/2 sample: RxD=1 -> IDLE (glitch rejected, no output); RxD=0 -> DATA, tick_cnt=0, bit_cnt=0.
- DATA: every OVERSAMPLE ticks sample RxD into shift register bit[bit_cnt] (LSB first); after DATA_BITS samples -> PARITY (if compiled in) else STOP.
- STOP: sample after OVERSAMPLE ticks; 0 sets frame_err. If STOP_BITS=2 sample a second stop bit; error if either is 0.
- On final stop sample, FSM returns to IDLE on the same clk edge (half-bit early for resync), and frame commits:
  - holding empty, or rx_valid&&rx_ready this cycle -> rx_data/rx_frame_err loaded, rx_valid=1 next clk.
  - holding full and not being read -> frame dropped, overrun_err pulses 1 clk, old data retained.
- Latency: rx_valid rises 1 clk after the tick of the last stop sample.
- rx_valid clears on the handshake unless a commit occurs in the same cycle (then stays 1 with new data).
- EN=0 mid-frame: immediate IDLE, partial frame discarded, no error. Reset mid-frame: everything cleared.
- Break (RxD held 0): frame with data 0 and frame_err=1, then no new start until RxD returns 1 (IDLE requires a 1 sample before arming).

Optional Feature:
- UART_RX_PARITY_EN: adds input parity_odd (1 bit) and output rx_parity_err (qualified by rx_valid); PARITY state samples one bit after data; error if XOR(data, parity bit) != parity_odd.
- Without the macro: no PARITY state, no extra ports; the frame is start+data+stop.

Decomposition:
- Shared package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP) and default OVERSAMPLE/DATA_BITS constants shared with the TX side.
- One natural sub-module: uart_sync_edge (2-flop synchroniser plus rising-edge pulse), instanced for BCLK and reused for RxD (level only).

Test Plan:
- Defaults, frame 0xA5, stop=1, rx_ready=1 -> rx_valid 1 clk, rx_data=0xA5, rx_frame_err=0.
- RxD low for 4 ticks then high -> no rx_valid, FSM back to IDLE, busy low.
- Frame 0x3C with stop=0 -> rx_data=0x3C, rx_frame_err=1.
- Frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun_err pulses once at the end of the second frame.
- EN dropped during bit 3 of 0xFF, re-raised, then 0x5A sent -> only 0x5A delivered.
- With UART_RX_PARITY_EN and parity_odd=0: frame 0x07 with parity bit 0 -> rx_parity_err=1; with parity bit 1 -> rx_parity_err=0.
